erx_router: RTL

// - Parametrised successor to the fixed 3-source RX distributor. Takes NSRC emesh sources (IO, EMMU,
//   DMA, cfg, ...), decodes each packet, round-robin arbitrates per destination, drives three

---
 rtl/erx_router_pkg.sv | 31 +++
 rtl/erx_rr_arbiter.sv | 37 +++
 rtl/erx_router.sv | 120 ++++++++++++
 3 files changed

// File: rtl/erx_router_pkg.sv
// Shared definitions for the erx RX router: emesh field offsets, group codes,
// destination encoding and the per-packet destination decode.
package erx_router_pkg;

  localparam int PKT_WRITE_BIT = 0;
  localparam int DSTADDR_LSB   = 8;
  localparam int DSTADDR_W     = 32;

  localparam logic [3:0] EGROUP_RR = 4'hE;

  typedef enum logic [1:0] {
    DST_WR = 2'd0,
    DST_RD = 2'd1,
    DST_RR = 2'd2
  } dst_e;

  localparam int NDST = 3;

  // A write aimed at this link's read-response group is a returning read response.
  function automatic dst_e decode_dst(
    input logic                 write,
    input logic [DSTADDR_W-1:0] dstaddr,
    input logic [11:0]          id,
    input logic [3:0]           rrgrp
  );
    if (write && (dstaddr[31:20] == id) && (dstaddr[19:16] == rrgrp)) return DST_RR;
    if (write) return DST_WR;
    return DST_RD;
  endfunction

endpackage

// File: rtl/erx_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr (cyclic scan)
// and returns the pointer to the slot after the winner.
module erx_rr_arbiter #(
  parameter int N    = 4,
  parameter int PTRW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [PTRW-1:0] next_ptr
);

  always_comb begin
    logic [PTRW:0]   sum;
    logic [PTRW-1:0] idx;
    logic            found;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PTRW+1)'(k);
      if (sum >= (PTRW+1)'(N)) sum = sum - (PTRW+1)'(N);
      idx = sum[PTRW-1:0];
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = (idx == PTRW'(N-1)) ? '0 : idx + PTRW'(1);
      end
    end
  end

endmodule

// File: rtl/erx_router.sv
// erx RX router: decodes NSRC emesh sources and round-robin arbitrates each of
// the write, read and read-response destinations into a registered output stage.
module erx_router
  import erx_router_pkg::*;
#(
  parameter int          PW    = 104,
  parameter int          NSRC  = 4,
  parameter logic [11:0] ID    = 12'h800,
  parameter logic [3:0]  RRGRP = EGROUP_RR
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NSRC-1:0]    src_access,
  input  logic [NSRC*PW-1:0] src_packet,
  output logic [NSRC-1:0]    src_wait,
  output logic               wr_access,
  output logic [PW-1:0]      wr_packet,
  input  logic               wr_wait,
  output logic               rd_access,
  output logic [PW-1:0]      rd_packet,
  input  logic               rd_wait,
  output logic               rr_access,
  output logic [PW-1:0]      rr_packet,
  input  logic               rr_wait,
  output logic               busy
);

  localparam int PTRW = $clog2(NSRC);

  dst_e              src_dst   [NSRC];
  logic [NSRC-1:0]   req       [NDST];
  logic [NSRC-1:0]   grant_d   [NDST];
  logic [PTRW-1:0]   ptr_q     [NDST];
  logic [PTRW-1:0]   ptr_nxt   [NDST];
  logic [PW-1:0]     pkt_q     [NDST];
  logic [PW-1:0]     load_pkt  [NDST];
  logic [NDST-1:0]   valid_q;
  logic [NDST-1:0]   stage_wait;
  logic [NDST-1:0]   can_load;
  logic [NDST-1:0]   grant_any;
  logic [NSRC-1:0]   grant_all;

  for (genvar i = 0; i < NSRC; i++) begin : g_decode
    assign src_dst[i] = decode_dst(src_packet[i*PW + PKT_WRITE_BIT],
                                   src_packet[i*PW + DSTADDR_LSB +: DSTADDR_W],
                                   ID, RRGRP);
  end

  always_comb begin
    for (int d = 0; d < NDST; d++) begin
      for (int i = 0; i < NSRC; i++) begin
        req[d][i] = src_access[i] && (src_dst[i] == dst_e'(d));
      end
    end
  end

  // A full stage may still load when its consumer is draining it this cycle.
  assign stage_wait = {rr_wait, rd_wait, wr_wait};
  assign can_load   = ~valid_q | ~stage_wait;

  for (genvar d = 0; d < NDST; d++) begin : g_arb
    erx_rr_arbiter #(
      .N    (NSRC),
      .PTRW (PTRW)
    ) u_arb (
      .req      (req[d]),
      .ptr      (ptr_q[d]),
      .en       (can_load[d]),
      .grant    (grant_d[d]),
      .next_ptr (ptr_nxt[d])
    );
  end

  always_comb begin
    grant_all = '0;
    for (int d = 0; d < NDST; d++) begin
      load_pkt[d]  = '0;
      grant_any[d] = |grant_d[d];
      grant_all    = grant_all | grant_d[d];
      for (int i = 0; i < NSRC; i++) begin
        if (grant_d[d][i]) load_pkt[d] = load_pkt[d] | src_packet[i*PW +: PW];
      end
    end
  end

  assign src_wait = nreset ? (src_access & ~grant_all) : '0;

  // NOTE: state registers use non-blocking assignments so every stage samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid_q <= '0;
      for (int d = 0; d < NDST; d++) begin
        // NOTE: the packet registers are cleared too, since the outputs must read
        // zero out of reset, not just be qualified by access.
        pkt_q[d] <= '0;
        ptr_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < NDST; d++) begin
        if (grant_any[d]) begin
          valid_q[d] <= 1'b1;
          pkt_q[d]   <= load_pkt[d];
          ptr_q[d]   <= ptr_nxt[d];
        end else if (!stage_wait[d]) begin
          valid_q[d] <= 1'b0;
        end
      end
    end
  end

  assign wr_access = valid_q[DST_WR];
  assign wr_packet = pkt_q[DST_WR];
  assign rd_access = valid_q[DST_RD];
  assign rd_packet = pkt_q[DST_RD];
  assign rr_access = valid_q[DST_RR];
  assign rr_packet = pkt_q[DST_RR];
  assign busy      = |valid_q;

endmodule
